// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide, one bit per cycle, stalling the phase clocks while busy.
// Shift-add multiply and restoring divide share the operand registers; signs are fixed up afterwards.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_100M,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            alu_complete,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
    state_t r_state, w_next;
    logic [2:0]        r_f;
    logic [XLEN-1:0]   r_a, r_b, r_q, r_rem, r_sres;
    logic [2*XLEN-1:0] r_acc, r_mc;
    logic              r_na, r_nb, r_spec;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_div, w_sa, w_sb, w_na, w_nb, w_dz, w_ovf, w_ge;
    logic              w_busy_d, w_ac_d, w_valid_d;
    logic [XLEN-1:0]   w_ma, w_mb, w_sres, w_quo, w_rm, w_final;
    logic [XLEN:0]     w_sh, w_sub;
    logic [2*XLEN-1:0] w_prod;
    always_comb begin
        w_div  = r_f[2];
        w_sa   = w_div ? ~r_f[0] : (r_f[1:0] == 2'b01 || r_f[1:0] == 2'b10);
        w_sb   = w_div ? ~r_f[0] : (r_f[1:0] == 2'b01);
        w_na   = w_sa & r_a[XLEN-1];
        w_nb   = w_sb & r_b[XLEN-1];
        w_ma   = w_na ? -r_a : r_a;
        w_mb   = w_nb ? -r_b : r_b;
        w_dz   = w_div && r_b == '0;
        w_ovf  = w_div && ~r_f[0] && r_a == {1'b1, {(XLEN-1){1'b0}}} && r_b == '1;
        w_sres = w_dz ? (r_f[1] ? r_a : '1) : (r_f[1] ? '0 : r_a);
        w_sh   = {r_rem, r_q[XLEN-1]};
        w_sub  = w_sh - {1'b0, r_mc[XLEN-1:0]};
        w_ge   = ~w_sub[XLEN];
        w_prod = (r_na ^ r_nb) ? -r_acc : r_acc;
        w_quo  = (r_na ^ r_nb) ? -r_q : r_q;
        w_rm   = r_na ? -r_rem : r_rem;
        w_final = r_spec ? r_sres :
                  !r_f[2] ? ((r_f[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]) :
                  (r_f[1] ? w_rm : w_quo);
    end
    always_ff @(posedge clk_100M or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    // Special cases pass through FIX without iterating, so their result lands two cycles after start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = start ? S_PREP : S_IDLE;
            S_PREP: w_next = (w_dz || w_ovf) ? S_FIX : S_CALC;
            S_CALC: w_next = (r_cnt == CNT_W'(XLEN-1)) ? S_FIX : S_CALC;
            S_FIX:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end
    always_comb begin
        w_busy_d  = w_next == S_PREP || w_next == S_CALC || w_next == S_FIX;
        w_ac_d    = ~w_busy_d;
        w_valid_d = w_next == S_DONE;
    end
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            alu_complete <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            r_f          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_q          <= '0;
            r_rem        <= '0;
            r_sres       <= '0;
            r_acc        <= '0;
            r_mc         <= '0;
            r_na         <= 1'b0;
            r_nb         <= 1'b0;
            r_spec       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            alu_complete <= w_ac_d;
            busy         <= w_busy_d;
            result_valid <= w_valid_d;
            if (r_state == S_FIX && w_next == S_DONE) result <= w_final;
            if (r_state == S_IDLE) begin
                r_f <= funct3;
                r_a <= op_a;
                r_b <= op_b;
            end
            if (r_state == S_PREP) begin
                r_na   <= w_na;
                r_nb   <= w_nb;
                r_spec <= w_dz | w_ovf;
                r_sres <= w_sres;
                r_cnt  <= '0;
                r_acc  <= '0;
                r_rem  <= '0;
                r_q    <= w_div ? w_ma : w_mb;
                r_mc   <= {{XLEN{1'b0}}, w_div ? w_mb : w_ma};
            end
            if (r_state == S_CALC) begin
                r_cnt <= r_cnt + 1'b1;
                if (!r_f[2]) begin
                    r_acc <= r_q[0] ? r_acc + r_mc : r_acc;
                    r_mc  <= r_mc << 1;
                    r_q   <= r_q >> 1;
                end else begin
                    r_rem <= w_ge ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
                    r_q   <= {r_q[XLEN-2:0], w_ge};
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random and directed RV32M ops against an arithmetic reference model,
// with a scoreboard queue drained by a monitor on every result_valid pulse.
module tb_muldiv_seq;
    logic        clk_100M = 0, rst_n = 0, start = 0, flush = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] op_a = 0, op_b = 0;
    logic        alu_complete, busy, result_valid;
    logic [31:0] result;
    int          checks = 0, errors = 0, cyc = 0;
    typedef struct {logic [31:0] res; int cyc;} exp_t;
    exp_t q[$];
    exp_t e;

    muldiv_seq dut (
        .clk_100M(clk_100M), .rst_n(rst_n), .start(start), .flush(flush),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .alu_complete(alu_complete),
        .busy(busy), .result(result), .result_valid(result_valid)
    );

    always #5 clk_100M = ~clk_100M;
    always @(posedge clk_100M) cyc <= cyc + 1;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endfunction

    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        int ia = $signed(a);
        int ib = $signed(b);
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk_100M)
        if (rst_n && result_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid result=%h expected no pulse", result);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("latency", cyc, e.cyc);
                chk("done_alu_complete", alu_complete, 1);
                chk("done_busy", busy, 0);
            end
        end

    // Called at a negedge with the DUT idle; returns one negedge after start was sampled.
    task automatic start_op(logic [2:0] f, logic [31:0] a, logic [31:0] b, bit push);
        bit sp = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        start = 1; funct3 = f; op_a = a; op_b = b;
        if (push) q.push_back('{model(f, a, b), cyc + (sp ? 3 : 35)});
        @(negedge clk_100M);
        start = 0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_done(bit poke_done);
        int n = 0;
        bit stalled = 1;
        while (!result_valid && n < 60) begin
            if (alu_complete) stalled = 0;
            @(negedge clk_100M);
            n++;
        end
        chk("done_within_bound", n < 60, 1);
        chk("stall_held", stalled, 1);
        if (poke_done) start = 1;
        @(negedge clk_100M);
        start = 0;
        if (poke_done) chk("start_in_done_ignored", busy, 0);
    endtask

    task automatic run(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        start_op(f, a, b, 1);
        wait_done(0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        repeat (3) @(negedge clk_100M);
        chk("reset_alu_complete", alu_complete, 1);
        chk("reset_busy", busy, 0);
        chk("reset_result", result, 0);
        chk("reset_valid", result_valid, 0);
        rst_n = 1;
        @(negedge clk_100M);
        run(3'd0, 32'd7, 32'hFFFF_FFFD);
        for (int f = 0; f < 4; f++) run(3'(f), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'd4, 32'hFFFF_FFF9, 32'd2);
        run(3'd6, 32'hFFFF_FFF9, 32'd2);
        run(3'd5, 32'd7, 32'd2);
        run(3'd7, 32'd7, 32'd2);
        run(3'd5, 32'd5, 32'd0);
        run(3'd6, 32'd5, 32'd0);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        // A second start during CALC must not queue another op.
        start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
        repeat (10) @(negedge clk_100M);
        start = 1; funct3 = 3'd5; op_a = 32'd99; op_b = 32'd3;
        @(negedge clk_100M);
        start = 0;
        wait_done(1);
        // Flush during CALC drops the op and leaves the old result in place.
        prev = result;
        start_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        repeat (11) @(negedge clk_100M);
        flush = 1;
        @(negedge clk_100M);
        flush = 0;
        chk("flush_alu_complete", alu_complete, 1);
        chk("flush_busy", busy, 0);
        chk("flush_result_held", result, prev);
        repeat (40) @(negedge clk_100M);
        start = 1; flush = 1;
        @(negedge clk_100M);
        start = 0; flush = 0;
        chk("flush_beats_start", busy, 0);
        repeat (3) @(negedge clk_100M);
        // Asynchronous reset in the middle of an op.
        run(3'd0, 32'd3, 32'd5);
        start_op(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF, 0);
        repeat (15) @(negedge clk_100M);
        #2 rst_n = 0;
        #1;
        chk("arst_alu_complete", alu_complete, 1);
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_valid", result_valid, 0);
        @(negedge clk_100M);
        rst_n = 1;
        @(negedge clk_100M);
        run(3'd2, 32'hFFFF_FFF0, 32'd16);
        for (int i = 0; i < 150; i++) run(3'($urandom), pick(), pick());
        repeat (5) @(negedge clk_100M);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
